// File: rtl/eac_prefix_stage.sv
// Carry/sum stage of a modulo 2^WIDTH-1 adder: Kogge-Stone prefix tree with end-around carry.
// Build option: define EAC_ZERO_NORM_EN to fold the all-ones zero onto all-zeros at the output.
module eac_prefix_stage #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             eac
);

  localparam int unsigned Levels = $clog2(WIDTH);

  logic             va_q, va_d;
  logic             vb_q, vb_d;
  logic [WIDTH-1:0] g_a_q, p_a_q;
  logic [WIDTH-1:0] sum_q;
  logic             eac_q;

  logic             adv_b;
  logic             accept;
  logic             load_b;

  // Handshake: B drains or is empty; A moves whenever B can take it.
  always_comb begin
    adv_b    = !vb_q || out_ready;
    in_ready = !va_q || adv_b;
    accept   = in_valid && in_ready;
    load_b   = adv_b && va_q;
    va_d     = va_q;
    vb_d     = vb_q;
    if (accept) begin
      va_d = 1'b1;
    end else if (adv_b) begin
      va_d = 1'b0;
    end
    if (adv_b) begin
      vb_d = va_q;
    end
  end

  // Parallel-prefix tree: level k combines spans at distance 2^k.
  genvar k, i;
  for (k = 0; k < Levels; k++) begin : g_lvl
    logic [WIDTH-1:0] gi, pi, go, po;
    if (k == 0) begin : g_first
      assign gi = g_a_q;
      assign pi = p_a_q;
    end else begin : g_next
      assign gi = g_lvl[k-1].go;
      assign pi = g_lvl[k-1].po;
    end
    for (i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= (1 << k)) begin : g_op
        assign go[i] = gi[i] | (pi[i] & gi[i-(1<<k)]);
        assign po[i] = pi[i] & pi[i-(1<<k)];
      end else begin : g_pass
        assign go[i] = gi[i];
        assign po[i] = pi[i];
      end
    end
  end

  logic [WIDTH-1:0] blk_g, blk_p;
  logic [WIDTH-1:0] carry;
  logic             eac_c;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH-1:0] sum_n;

  assign blk_g = g_lvl[Levels-1].go;
  assign blk_p = g_lvl[Levels-1].po;

  // One end-around pass suffices: a carry-in can never create a second carry-out.
  always_comb begin
    eac_c = blk_g[WIDTH-1];
    carry = blk_g | (blk_p & {WIDTH{eac_c}});
    sum_c = p_a_q ^ {carry[WIDTH-2:0], eac_c};
`ifdef EAC_ZERO_NORM_EN
    sum_n = (&sum_c) ? '0 : sum_c;
`else
    sum_n = sum_c;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      va_q  <= 1'b0;
      vb_q  <= 1'b0;
      g_a_q <= '0;
      p_a_q <= '0;
      sum_q <= '0;
      eac_q <= 1'b0;
    end else begin
      va_q <= va_d;
      vb_q <= vb_d;
      if (accept) begin
        g_a_q <= g;
        p_a_q <= p;
      end
      if (load_b) begin
        sum_q <= sum_n;
        eac_q <= eac_c;
      end
    end
  end

  assign out_valid = vb_q;
  assign sum       = sum_q;
  assign eac       = eac_q;

endmodule

// File: tb/tb_eac_prefix_stage.sv
// Directed/scoreboard bench for eac_prefix_stage at WIDTH=8.
module tb_eac_prefix_stage;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] g;
  logic [7:0] p;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       eac;

  typedef struct packed {
    logic [7:0] sum;
    logic       eac;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   beats_out = 0;

  eac_prefix_stage #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .g         (g),
    .p         (p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .eac       (eac)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] x, input logic [7:0] y);
    logic [8:0] raw;
    exp_t       e;
    raw   = {1'b0, x} + {1'b0, y};
    e.eac = raw[8];
    e.sum = raw[7:0] + {7'b0, raw[8]};
`ifdef EAC_ZERO_NORM_EN
    if (e.sum == 8'hFF) e.sum = 8'h00;
`endif
    return e;
  endfunction

  // Output side of the scoreboard: a beat transfers at the posedge following this sample.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      beats_out++;
      if (sb.size() == 0) begin
        check("unexpected_out", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum", sum, e.sum);
        check("eac", eac, e.eac);
      end
    end
  end

  // Holds in_valid with the given operands until accepted; leaves in_valid high.
  task automatic send(input logic [7:0] x, input logic [7:0] y, output int cyc);
    logic acc;
    logic done;
    in_valid = 1'b1;
    g        = x & y;
    p        = x ^ y;
    cyc      = 0;
    done     = 1'b0;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      cyc++;
      if (acc) begin
        sb.push_back(model(x, y));
        done = 1'b1;
      end
    end
    if (!done) check("send_timeout", done, 1'b1);
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 40 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    check(tag, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int         c;
    int         total;
    int         snap;
    logic [7:0] held_sum;
    logic       held_eac;
    logic [7:0] xs [6];
    logic [7:0] ys [6];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    g         = '0;
    p         = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_eac", eac, 1'b0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Latency: out_valid must not rise one edge after accept, but on the next.
    send(8'd5, 8'd3, c);
    in_valid = 1'b0;
    check("lat_early", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_valid", out_valid, 1'b1);
    check("lat_sum", sum, 8'h08);
    drain("drain_basic");

    // Wrap, both zero encodings, and all-generate inputs.
    xs = '{8'd200, 8'd0,   8'd255, 8'd255, 8'd128, 8'd1};
    ys = '{8'd100, 8'd255, 8'd0,   8'd255, 8'd128, 8'd254};
    for (int n = 0; n < 6; n++) send(xs[n], ys[n], c);
    in_valid = 1'b0;
    drain("drain_directed");

    // Backpressure: two accepts fill the pipe, then in_ready must drop and the output hold.
    out_ready = 1'b0;
    send(8'd10, 8'd20, c);
    send(8'd250, 8'd9, c);
    g = 8'd33 & 8'd44;
    p = 8'd33 ^ 8'd44;
    @(negedge clk);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    held_sum = sum;
    held_eac = eac;
    check("bp_first_sum", held_sum, 8'd30);
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      check("bp_hold_sum", sum, held_sum);
      check("bp_hold_eac", eac, held_eac);
      check("bp_hold_ready", in_ready, 1'b0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(8'd33, 8'd44, c);
    send(8'd77, 8'd200, c);
    in_valid = 1'b0;
    drain("drain_bp");

    // Streaming: every send must be accepted on its first cycle.
    total = 0;
    for (int n = 0; n < 16; n++) begin
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), c);
      total += c;
    end
    in_valid = 1'b0;
    check("stream_cycles", total, 16);
    drain("drain_stream");

    // Reset mid-flight with both stages full.
    out_ready = 1'b0;
    send(8'd100, 8'd100, c);
    send(8'd7, 8'd9, c);
    in_valid = 1'b0;
    check("mf_full", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mf_out_valid", out_valid, 1'b0);
    check("mf_sum", sum, 8'h00);
    check("mf_eac", eac, 1'b0);
    check("mf_in_ready", in_ready, 1'b1);
    sb.delete();
    snap = beats_out;
    @(negedge clk);
    #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("mf_no_stale", beats_out, snap);
    check("mf_idle", out_valid, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
